lcd_value_display: RTL and testbench

//  Upstream feeder for lcd_init: takes two 16-bit unsigned values, converts each to 5 decimal digits
//  (sequential double-dabble), composes the 34-byte two-line text frame and pulses sendText.

---
 rtl/lcd_value_display.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_value_display.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_value_display.sv
// lcd_value_display: converts two 16-bit values to decimal and hands a 34-byte
// two-line text frame ("\nA=ddddd         \nB=ddddd         ") to lcd_init.
// Ports:
//   CLK, RST            clock and synchronous active-high reset
//   update              1-cycle strobe; value_a/value_b are captured on it
//   value_a, value_b    unsigned values shown on line 1 / line 2
//   sendingDone         downstream level flag, a rising edge ends the frame
//   sendText            1-cycle start strobe to downstream
//   text                frame, byte 1 in the MSBs [8*TEXT_LENGTH:8*TEXT_LENGTH-7]
//   busy                high whenever the FSM is not idle
//   timeout_err         sticky, set when the downstream never reports done
module lcd_value_display #(
  parameter int TEXT_LENGTH    = 34,
  parameter bit BLANK_ZEROS    = 1'b1,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     update,
  input  logic [15:0]              value_a,
  input  logic [15:0]              value_b,
  input  logic                     sendingDone,
  output logic                     sendText,
  output logic [8*TEXT_LENGTH:1]   text,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8*TEXT_LENGTH:1] RESET_TEXT =
    {8'h0A, {16{8'h20}}, 8'h0A, {16{8'h20}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CONV_A, S_CONV_B, S_BUILD, S_SEND, S_WAIT_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [15:0]              shadow_a_q, shadow_a_d;
  logic [15:0]              shadow_b_q, shadow_b_d;
  logic [15:0]              snap_b_q, snap_b_d;     // B value frozen at frame start
  logic [15:0]              bin_q, bin_d;
  logic [19:0]              bcd_q, bcd_d;
  logic [19:0]              digits_a_q, digits_a_d;
  logic [3:0]               iter_q, iter_d;
  logic                     pending_q, pending_d;
  logic                     sd_prev_q;
  logic                     send_q, send_d;
  logic [8*TEXT_LENGTH:1]   text_q, text_d;
  logic                     to_err_q, to_err_d;
  logic [TW-1:0]            to_cnt_q, to_cnt_d;
  logic [35:0]              step;
  logic                     sd_rise;
  logic                     start;

  // One double-dabble iteration on {bcd, bin}: correct digits >= 5, then shift.
  function automatic logic [35:0] dd_step(input logic [35:0] v);
    logic [35:0] t;
    t = v;
    for (int k = 0; k < 5; k++) begin
      if (t[16+4*k +: 4] >= 4'd5) t[16+4*k +: 4] = t[16+4*k +: 4] + 4'd3;
    end
    return {t[34:0], 1'b0};
  endfunction

  // Five ASCII digits, MSD in the top byte; leading zeros blanked except the last.
  function automatic logic [39:0] digit_bytes(input logic [19:0] d);
    logic [39:0] r;
    logic        lead;
    logic [3:0]  n;
    r    = '0;
    lead = 1'b1;
    for (int k = 4; k >= 0; k--) begin
      n = d[4*k +: 4];
      if (BLANK_ZEROS && lead && (n == 4'd0) && (k != 0)) begin
        r[8*k +: 8] = 8'h20;
      end else begin
        r[8*k +: 8] = 8'h30 + {4'h0, n};
        lead        = 1'b0;
      end
    end
    return r;
  endfunction

  assign step    = dd_step({bcd_q, bin_q});
  // Only a fresh rising edge ends the frame; a level left high from before is ignored.
  assign sd_rise = sendingDone & ~sd_prev_q;

  always_comb begin
    state_d    = state_q;
    shadow_a_d = update ? value_a : shadow_a_q;
    shadow_b_d = update ? value_b : shadow_b_q;
    snap_b_d   = snap_b_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    digits_a_d = digits_a_q;
    iter_d     = iter_q;
    pending_d  = pending_q;
    send_d     = 1'b0;
    text_d     = text_q;
    to_err_d   = to_err_q;
    to_cnt_d   = to_cnt_q;
    start      = 1'b0;

    if (update && (state_q != S_IDLE)) pending_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (update) start = 1'b1;
      end
      S_CONV_A: begin
        {bcd_d, bin_d} = step;
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          digits_a_d = step[35:16];
          bcd_d      = '0;
          bin_d      = snap_b_q;
          iter_d     = '0;
          state_d    = S_CONV_B;
        end
      end
      S_CONV_B: begin
        {bcd_d, bin_d} = step;
        iter_d         = iter_q + 4'd1;
        // B digits stay in bcd_q through BUILD.
        if (iter_q == 4'd15) state_d = S_BUILD;
      end
      S_BUILD: begin
        text_d  = {8'h0A, "A=", digit_bytes(digits_a_q), {9{8'h20}},
                   8'h0A, "B=", digit_bytes(bcd_q),      {9{8'h20}}};
        state_d = S_SEND;
      end
      S_SEND: begin
        send_d   = 1'b1;
        to_cnt_d = '0;
        state_d  = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (sd_rise) begin
          // pending_d already includes a strobe arriving in this very cycle.
          if (pending_d) start = 1'b1;
          else           state_d = S_IDLE;
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          to_err_d  = 1'b1;
          pending_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame start: convert the latest shadows; A and B are frozen together.
    if (start) begin
      state_d   = S_CONV_A;
      pending_d = 1'b0;
      bin_d     = shadow_a_d;
      snap_b_d  = shadow_b_d;
      bcd_d     = '0;
      iter_d    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      snap_b_q   <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      digits_a_q <= '0;
      iter_q     <= '0;
      pending_q  <= 1'b0;
      sd_prev_q  <= 1'b0;
      send_q     <= 1'b0;
      text_q     <= RESET_TEXT;
      to_err_q   <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
      snap_b_q   <= snap_b_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      digits_a_q <= digits_a_d;
      iter_q     <= iter_d;
      pending_q  <= pending_d;
      sd_prev_q  <= sendingDone;
      send_q     <= send_d;
      text_q     <= text_d;
      to_err_q   <= to_err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign sendText    = send_q;
  assign text        = text_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_lcd_value_display.sv
// Bench for lcd_value_display: two instances (blanked and zero-padded digits)
// share one stimulus stream; frames are compared against a decimal reference model.
module tb_lcd_value_display;

  localparam int TO = 600;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         update = 1'b0;
  logic [15:0]  value_a = '0;
  logic [15:0]  value_b = '0;
  logic         sendingDone = 1'b0;
  logic         send_b, send_z, busy_b, busy_z, err_b, err_z;
  logic [272:1] text_b, text_z;

  int n_vec = 0;
  int n_err = 0;
  int n_send_b = 0;
  int n_send_z = 0;
  int exp_sends = 0;

  always #5 CLK = ~CLK;

  lcd_value_display #(.TEXT_LENGTH(34), .BLANK_ZEROS(1'b1), .TIMEOUT_CYCLES(TO)) u_dut (
    .CLK(CLK), .RST(RST), .update(update), .value_a(value_a), .value_b(value_b),
    .sendingDone(sendingDone), .sendText(send_b), .text(text_b), .busy(busy_b),
    .timeout_err(err_b));

  lcd_value_display #(.TEXT_LENGTH(34), .BLANK_ZEROS(1'b0), .TIMEOUT_CYCLES(TO)) u_dut_z (
    .CLK(CLK), .RST(RST), .update(update), .value_a(value_a), .value_b(value_b),
    .sendingDone(sendingDone), .sendText(send_z), .text(text_z), .busy(busy_z),
    .timeout_err(err_z));

  always @(negedge CLK) begin
    if (send_b) n_send_b++;
    if (send_z) n_send_z++;
  end

  task automatic chk(input string tag, input logic [271:0] got, input logic [271:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Decimal character k (0 = most significant) of v, computed with plain arithmetic.
  function automatic logic [7:0] dchar(input int v, input int k, input bit blank);
    int pw[5] = '{10000, 1000, 100, 10, 1};
    if (blank && k < 4 && v < pw[k]) return 8'h20;
    return 8'h30 + 8'((v / pw[k]) % 10);
  endfunction

  function automatic logic [271:0] pack(input logic [7:0] c[34]);
    logic [271:0] f;
    for (int i = 0; i < 34; i++) f[271-8*i -: 8] = c[i];
    return f;
  endfunction

  function automatic logic [271:0] model_frame(input int a, input int b, input bit blank);
    logic [7:0] c[34];
    for (int i = 0; i < 34; i++) c[i] = 8'h20;
    c[0] = 8'h0A; c[1] = "A"; c[2] = "=";
    c[17] = 8'h0A; c[18] = "B"; c[19] = "=";
    for (int k = 0; k < 5; k++) begin
      c[3+k]  = dchar(a, k, blank);
      c[20+k] = dchar(b, k, blank);
    end
    return pack(c);
  endfunction

  function automatic logic [271:0] reset_frame();
    logic [7:0] c[34];
    for (int i = 0; i < 34; i++) c[i] = 8'h20;
    c[0] = 8'h0A; c[17] = 8'h0A;
    return pack(c);
  endfunction

  // Ticks until sendText is seen; -1 if it never comes within the budget.
  task automatic wait_send(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (send_b) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_frame(input int a, input int b, input string tag);
    int lat;
    wait_send(lat);
    exp_sends++;
    chk({tag, "_latency"}, lat, 34);
    chk({tag, "_send_z"}, send_z, 1'b1);
    chk({tag, "_text"}, text_b, model_frame(a, b, 1'b1));
    chk({tag, "_text_z"}, text_z, model_frame(a, b, 1'b0));
    tick();
    chk({tag, "_pulse"}, send_b, 1'b0);
  endtask

  task automatic run_frame(input int a, input int b, input string tag);
    update = 1'b1; value_a = 16'(a); value_b = 16'(b);
    tick();
    update = 1'b0;
    chk({tag, "_busy"}, busy_b, 1'b1);
    check_frame(a, b, tag);
  endtask

  task automatic done_edge();
    sendingDone = 1'b0;
    tick();
    sendingDone = 1'b1;
    tick();
  endtask

  initial begin
    int a, b;
    repeat (3) tick();
    RST = 1'b0;
    tick();
    chk("rst_send", send_b, 1'b0);
    chk("rst_busy", busy_b, 1'b0);
    chk("rst_err", err_b, 1'b0);
    chk("rst_text", text_b, reset_frame());

    run_frame(12345, 42, "basic");
    done_edge();
    chk("basic_idle", busy_b, 1'b0);

    run_frame(0, 65535, "extremes");
    done_edge();
    chk("extremes_idle", busy_b, 1'b0);

    // sendingDone still high from the previous frame: must not end this one.
    run_frame(int'($urandom_range(0, 65535)), 7, "held");
    repeat (20) tick();
    chk("held_high_ignored", busy_b, 1'b1);
    sendingDone = 1'b0;
    repeat (500) tick();
    chk("held_low_wait", busy_b, 1'b1);
    sendingDone = 1'b1;
    tick();
    chk("held_rise_exit", busy_b, 1'b0);

    // Three strobes while waiting collapse into one frame with the last value.
    run_frame(100, 200, "pend_first");
    for (int i = 1; i <= 3; i++) begin
      update = 1'b1; value_a = 16'(i); value_b = 16'd7;
      tick();
      update = 1'b0;
      tick();
    end
    done_edge();
    check_frame(3, 7, "pend_second");
    done_edge();
    chk("pend_idle", busy_b, 1'b0);
    repeat (60) tick();
    chk("pend_no_extra", n_send_b, exp_sends);

    // Strobe in the same cycle as the done edge starts a new frame.
    run_frame(5, 6, "simul_first");
    sendingDone = 1'b0;
    tick();
    sendingDone = 1'b1; update = 1'b1; value_a = 16'd777; value_b = 16'd888;
    tick();
    update = 1'b0;
    check_frame(777, 888, "simul_second");
    done_edge();
    chk("simul_idle", busy_b, 1'b0);

    // Timeout: downstream never reports done.
    sendingDone = 1'b0;
    run_frame(31, 9, "tmo");
    repeat (TO - 2) tick();
    chk("tmo_before_busy", busy_b, 1'b1);
    chk("tmo_before_err", err_b, 1'b0);
    tick();
    chk("tmo_err", err_b, 1'b1);
    chk("tmo_idle", busy_b, 1'b0);
    run_frame(65535, 10, "tmo_after");
    done_edge();
    chk("tmo_sticky", err_b, 1'b1);

    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, 65535));
      b = (i == 0) ? 9 : int'($urandom_range(0, 65535 >> (3 * i)));
      run_frame(a, b, "rand");
      done_edge();
      chk("rand_idle", busy_b, 1'b0);
    end

    // Reset during CONV_B with a simultaneous strobe: reset wins.
    update = 1'b1; value_a = 16'd4321; value_b = 16'd1234;
    tick();
    update = 1'b0;
    repeat (20) tick();
    RST = 1'b1; update = 1'b1; value_a = 16'd9999;
    tick();
    RST = 1'b0; update = 1'b0;
    chk("midrst_busy", busy_b, 1'b0);
    chk("midrst_send", send_b, 1'b0);
    chk("midrst_err", err_b, 1'b0);
    chk("midrst_text", text_b, reset_frame());
    chk("midrst_text_z", text_z, reset_frame());
    repeat (40) tick();
    chk("midrst_discard", busy_b, 1'b0);
    run_frame(50001, 1, "midrst_after");
    done_edge();

    chk("total_sends", n_send_b, exp_sends);
    chk("total_sends_z", n_send_z, exp_sends);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
